// File: rtl/hit_damage_ctrl.sv
// Attack/damage controller for one fighter: key edge -> windup -> hitbox test -> hit strobe -> cooldown.
// Tracks the victim's damage percent and the damage-scaled knockback distance.
module hit_damage_ctrl #(
    parameter logic [7:0]  ATTACK_KEY    = 8'h2C,
    parameter int unsigned WINDUP_FRAMES = 4,
    parameter int unsigned HIT_FRAMES    = 6,
    parameter int unsigned COOL_FRAMES   = 20,
    parameter int unsigned REACH         = 20,
    parameter int unsigned DMG_PER_HIT   = 12,
    parameter int unsigned DMG_MAX       = 999,
    parameter int unsigned KB_BASE       = 64,
    parameter int unsigned KB_SCALE      = 8
) (
    input  logic        frame_clk,
    input  logic        Reset_n,
    input  logic [7:0]  keycode_1,
    input  logic [7:0]  keycode_2,
    input  logic [7:0]  keycode_3,
    input  logic [7:0]  keycode_4,
    input  logic [9:0]  AtkX,
    input  logic [9:0]  AtkY,
    input  logic [9:0]  AtkW,
    input  logic [9:0]  AtkH,
    input  logic [9:0]  VicX,
    input  logic [9:0]  VicY,
    input  logic [9:0]  VicW,
    input  logic [9:0]  VicH,
    input  logic        vic_death,
    output logic        hit,
    output logic [12:0] launch_dist,
    output logic [9:0]  damage,
    output logic        attacking,
    output logic [2:0]  fsm_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WINDUP = 3'd1;
    localparam logic [2:0] S_ACTIVE = 3'd2;
    localparam logic [2:0] S_HIT    = 3'd3;
    localparam logic [2:0] S_COOL   = 3'd4;

    logic [2:0]  state, state_d;
    logic [5:0]  cnt, cnt_d;
    logic        key_prev, press, press_edge;
    logic [9:0]  damage_d, dmg_new;
    logic [12:0] launch_d, launch_new;
    logic [10:0] dmg_sum;
    logic [16:0] kb_sum;
    logic [11:0] atk_l, atk_r, atk_b, vic_r, vic_b;
    logic        overlap;

    assign press = (keycode_1 == ATTACK_KEY) || (keycode_2 == ATTACK_KEY) ||
                   (keycode_3 == ATTACK_KEY) || (keycode_4 == ATTACK_KEY);
    assign press_edge = press && !key_prev;
    assign fsm_state  = state;

    // 12-bit sums so X+W+REACH cannot wrap; the left edge clamps at 0 instead of underflowing.
    assign atk_l = ({2'b00, AtkX} >= 12'(REACH)) ? ({2'b00, AtkX} - 12'(REACH)) : 12'd0;
    assign atk_r = {2'b00, AtkX} + {2'b00, AtkW} + 12'(REACH);
    assign atk_b = {2'b00, AtkY} + {2'b00, AtkH};
    assign vic_r = {2'b00, VicX} + {2'b00, VicW};
    assign vic_b = {2'b00, VicY} + {2'b00, VicH};
    assign overlap = (atk_l < vic_r) && ({2'b00, VicX} < atk_r) &&
                     ({2'b00, AtkY} < vic_b) && ({2'b00, VicY} < atk_b);

    assign dmg_sum    = {1'b0, damage} + 11'(DMG_PER_HIT);
    assign dmg_new    = (dmg_sum > 11'(DMG_MAX)) ? 10'(DMG_MAX) : dmg_sum[9:0];
    assign kb_sum     = 17'(KB_BASE) + 17'(KB_SCALE) * {7'd0, dmg_new};
    assign launch_new = (kb_sum > 17'd8191) ? 13'h1FFF : kb_sum[12:0];

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        damage_d = damage;
        launch_d = launch_dist;
        case (state)
            S_IDLE: begin
                if (press_edge) begin
                    state_d = S_WINDUP;
                    cnt_d   = 6'(WINDUP_FRAMES - 1);
                end
            end
            S_WINDUP: begin
                if (cnt == 6'd0) state_d = S_ACTIVE;
                else             cnt_d   = cnt - 6'd1;
            end
            S_ACTIVE: begin
                // A death on the connect frame cancels the hit outright.
                if (overlap && !vic_death) begin
                    state_d  = S_HIT;
                    cnt_d    = 6'(HIT_FRAMES - 1);
                    damage_d = dmg_new;
                    launch_d = launch_new;
                end else begin
                    state_d = S_COOL;
                    cnt_d   = 6'(COOL_FRAMES - 1);
                end
            end
            S_HIT: begin
                if (vic_death || cnt == 6'd0) begin
                    state_d = S_COOL;
                    cnt_d   = 6'(COOL_FRAMES - 1);
                end else begin
                    cnt_d = cnt - 6'd1;
                end
            end
            S_COOL: begin
                if (cnt == 6'd0) state_d = S_IDLE;
                else             cnt_d   = cnt - 6'd1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
        if (vic_death) begin
            damage_d = 10'd0;
            launch_d = 13'(KB_BASE);
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            cnt         <= 6'd0;
            key_prev    <= 1'b0;
            damage      <= 10'd0;
            launch_dist <= 13'(KB_BASE);
            hit         <= 1'b0;
            attacking   <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            key_prev    <= press;
            damage      <= damage_d;
            launch_dist <= launch_d;
            hit         <= (state_d == S_HIT);
            attacking   <= (state_d == S_WINDUP) || (state_d == S_ACTIVE);
        end
    end

endmodule
